// File: rtl/cmsdk_ahb_dma_copier_pkg.sv
// Shared constants and FSM state type for the single-channel AHB-Lite word copier.
package cmsdk_ahb_dma_copier_pkg;

  localparam logic [1:0] HTRANS_IDLE     = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;
  localparam logic [2:0] HSIZE_WORD      = 3'b010;
  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRdA  = 3'd1,
    StRdD  = 3'd2,
    StWrA  = 3'd3,
    StWrD  = 3'd4,
    StFin  = 3'd5
  } state_e;

  // Word stride; wraps silently at the top of the 32-bit space.
  function automatic logic [31:0] addr_next(input logic [31:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/cmsdk_ahb_dma_copier_if.sv
// AHB-Lite manager-side signal bundle for the word copier.
interface cmsdk_ahb_dma_copier_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HADDR, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWRITE, HWDATA,
    input  HREADY, HRDATA, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWRITE, HWDATA,
    output HREADY, HRDATA, HRESP
  );
endinterface

// File: rtl/cmsdk_ahb_dma_copier.sv
// Single-channel AHB-Lite manager copying len 32-bit words from src to dst.
// Each word is a read (address + data phase) then a write (address + data phase),
// never overlapped. Optional feature macro: CMSDK_AHB_DMA_CHKSUM_EN adds an
// XOR checksum of every word read.
module cmsdk_ahb_dma_copier
  import cmsdk_ahb_dma_copier_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             cmd_start,
  input  logic [31:0]      cmd_src,
  input  logic [31:0]      cmd_dst,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             busy,
  output logic             done,
  output logic             error,
  cmsdk_ahb_dma_copier_if.master ahb
`ifdef CMSDK_AHB_DMA_CHKSUM_EN
  ,
  output logic [31:0]      chksum
`endif
);

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      buf_q, buf_d;
  logic             err_q, err_d;   // termination cause, consumed in StFin
  logic             done_q, done_d;
  logic             error_q, error_d;
`ifdef CMSDK_AHB_DMA_CHKSUM_EN
  logic [31:0]      chksum_q, chksum_d;
`endif

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q  <= StIdle;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      buf_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
`ifdef CMSDK_AHB_DMA_CHKSUM_EN
      chksum_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      buf_q    <= buf_d;
      err_q    <= err_d;
      done_q   <= done_d;
      error_q  <= error_d;
`ifdef CMSDK_AHB_DMA_CHKSUM_EN
      chksum_q <= chksum_d;
`endif
    end
  end

  // Next-state and datapath updates; every phase advances only on HREADY.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    buf_d    = buf_q;
    err_d    = err_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
`ifdef CMSDK_AHB_DMA_CHKSUM_EN
    chksum_d = chksum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd_start) begin
          src_d   = cmd_src & ~32'h3;
          dst_d   = cmd_dst & ~32'h3;
          len_d   = cmd_len;
          err_d   = 1'b0;
`ifdef CMSDK_AHB_DMA_CHKSUM_EN
          chksum_d = '0;
`endif
          state_d = (cmd_len == '0) ? StFin : StRdA;
        end
      end
      StRdA: begin
        if (ahb.HREADY) state_d = StRdD;
      end
      StRdD: begin
        // ERROR is acted on in its first (HREADY=0) cycle so no new NONSEQ follows.
        if (ahb.HRESP) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else if (ahb.HREADY) begin
          buf_d   = ahb.HRDATA;
`ifdef CMSDK_AHB_DMA_CHKSUM_EN
          chksum_d = chksum_q ^ ahb.HRDATA;
`endif
          state_d = StWrA;
        end
      end
      StWrA: begin
        if (ahb.HREADY) state_d = StWrD;
      end
      StWrD: begin
        if (ahb.HRESP) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else if (ahb.HREADY) begin
          src_d   = addr_next(src_q);
          dst_d   = addr_next(dst_q);
          len_d   = len_q - LEN_W'(1);
          state_d = (len_q == LEN_W'(1)) ? StFin : StRdA;
        end
      end
      StFin: begin
        done_d  = ~err_q;
        error_d = err_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs decoded from the current state; stable while a phase is stalled.
  always_comb begin
    ahb.HTRANS    = HTRANS_IDLE;
    ahb.HADDR     = '0;
    ahb.HWRITE    = 1'b0;
    ahb.HWDATA    = '0;
    ahb.HSIZE     = HSIZE_WORD;
    ahb.HBURST    = HBURST_SINGLE;
    ahb.HPROT     = HPROT_DATA_PRIV;
    ahb.HMASTLOCK = 1'b0;
    unique case (state_q)
      StRdA: begin
        ahb.HTRANS = HTRANS_NONSEQ;
        ahb.HADDR  = src_q;
      end
      StRdD: ahb.HADDR = src_q;
      StWrA: begin
        ahb.HTRANS = HTRANS_NONSEQ;
        ahb.HWRITE = 1'b1;
        ahb.HADDR  = dst_q;
      end
      StWrD: begin
        ahb.HADDR  = dst_q;
        ahb.HWDATA = buf_q;
      end
      default: ;
    endcase
  end

  assign busy  = (state_q != StIdle);
  assign done  = done_q;
  assign error = error_q;
`ifdef CMSDK_AHB_DMA_CHKSUM_EN
  assign chksum = chksum_q;
`endif

endmodule

// File: tb/tb_cmsdk_ahb_dma_copier.sv
// Self-checking bench for cmsdk_ahb_dma_copier: a memory-backed AHB subordinate with
// random wait states and error injection, plus a transfer-level reference model.
module tb_cmsdk_ahb_dma_copier;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_start = 1'b0;
  logic [31:0] cmd_src = '0;
  logic [31:0] cmd_dst = '0;
  logic [15:0] cmd_len = '0;
  logic        busy, done, error;
`ifdef CMSDK_AHB_DMA_CHKSUM_EN
  logic [31:0] chksum;
`endif

  cmsdk_ahb_dma_copier_if bus ();

  cmsdk_ahb_dma_copier #(.LEN_W(16)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .cmd_start (cmd_start),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_len   (cmd_len),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .ahb       (bus)
`ifdef CMSDK_AHB_DMA_CHKSUM_EN
    ,
    .chksum    (chksum)
`endif
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle", name, act, exp);
    end
  endtask

  // Sparse memory; untouched words read back as fresh random values.
  bit [31:0] mem [bit [31:0]];
  function automatic bit [31:0] mem_rd(input bit [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // Subordinate state
  bit        dp_active, dp_write, dp_err;
  bit [31:0] dp_addr;
  int        dp_wait, err_stage;
  int        wr_count;
  int        err_target = -1;
  bit        stall_en = 1'b0;

  // Reference model: phase 0 idle, 1 copying, 2 terminating, 3 pulse cycle
  int        phase = 0;
  bit [31:0] m_src, m_dst, m_buf, chk_model;
  int        m_left, m_idx;
  bit        m_next_wr, m_err;
  bit        term_v;
  int        old_v;

  // Observation totals (monotonic; tests take differences)
  int        cyc = 0;
  int        tot_busy = 0, tot_done = 0, tot_err = 0, last_done_cyc = 0;
  int        n_nonseq = 0, n_writes_ok = 0;
  bit [31:0] read_log[$];
  bit        hold_pending;
  bit [31:0] hold_addr;
  bit        hold_write;
  bit        chk_on = 1'b0;

  // Subordinate response for the coming edge, driven mid-cycle.
  always @(negedge HCLK) begin
    if (dp_active) begin
      if (dp_wait > 0) begin
        bus.HREADY = 1'b0; bus.HRESP = 1'b0; dp_wait--;
      end else if (dp_err && err_stage == 0) begin
        bus.HREADY = 1'b0; bus.HRESP = 1'b1; err_stage = 1;
      end else if (dp_err) begin
        bus.HREADY = 1'b1; bus.HRESP = 1'b1;
      end else begin
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        if (!dp_write) bus.HRDATA = mem_rd(dp_addr);
      end
    end else begin
      bus.HRESP  = 1'b0;
      bus.HREADY = (stall_en && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      bus.HRDATA = $urandom;
    end
  end

  // Edge-time bookkeeping: bus transfers, data checks and the model's phase.
  always @(posedge HCLK) begin
    cyc++;
    term_v = 1'b0;
    if (!HRESETn) begin
      dp_active = 1'b0; phase = 0; hold_pending = 1'b0; chk_model = '0; m_err = 1'b0;
    end else begin
      hold_pending = (bus.HTRANS == 2'b10) && !bus.HREADY;
      hold_addr    = bus.HADDR;
      hold_write   = bus.HWRITE;
      if (dp_active) begin
        if (dp_err && bus.HRESP && !bus.HREADY) begin
          term_v = 1'b1; m_err = 1'b1;
        end
        if (bus.HREADY) begin
          if (!dp_err) begin
            if (dp_write) begin
              check("hwdata", bus.HWDATA, m_buf);
              mem[dp_addr] = bus.HWDATA;
              n_writes_ok++; m_idx++; m_left--;
              if (m_left == 0) term_v = 1'b1;
            end else begin
              m_buf = bus.HRDATA;
              chk_model ^= bus.HRDATA;
            end
          end
          dp_active = 1'b0;
        end
      end
      if (bus.HTRANS == 2'b10 && bus.HREADY) begin
        n_nonseq++;
        check("nonseq_only_while_copying", 32'(phase == 1), 32'd1);
        check("haddr", bus.HADDR, m_next_wr ? m_dst + 32'(4 * m_idx) : m_src + 32'(4 * m_idx));
        check("hwrite", bus.HWRITE, m_next_wr);
        if (!bus.HWRITE) read_log.push_back(bus.HADDR);
        dp_active = 1'b1; dp_addr = bus.HADDR; dp_write = bus.HWRITE;
        dp_wait   = stall_en ? $urandom_range(0, 3) : 0;
        dp_err    = bus.HWRITE && (wr_count == err_target);
        if (bus.HWRITE) wr_count++;
        err_stage = 0;
        m_next_wr = !m_next_wr;
      end
      old_v = phase;
      case (old_v)
        1: if (term_v) phase = 2;
        2: phase = 3;
        3: phase = 0;
        default: ;
      endcase
      if (cmd_start && (old_v == 0 || old_v == 3)) begin
        m_src = cmd_src & ~32'h3; m_dst = cmd_dst & ~32'h3;
        m_left = int'(cmd_len); m_idx = 0; m_next_wr = 1'b0; m_err = 1'b0;
        chk_model = '0; wr_count = 0;
        phase = (cmd_len == 16'd0) ? 2 : 1;
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge HCLK) begin
    if (chk_on) begin
      check("busy", 32'(busy), 32'(phase == 1 || phase == 2));
      check("done", 32'(done), 32'(phase == 3 && !m_err));
      check("error", 32'(error), 32'(phase == 3 && m_err));
      check("ctl_const", 32'({bus.HSIZE, bus.HBURST, bus.HPROT, bus.HMASTLOCK}),
            32'({3'b010, 3'b000, 4'b0011, 1'b0}));
      if (phase != 1) check("htrans_idle", 32'(bus.HTRANS), 32'd0);
      else check("htrans_legal", 32'(bus.HTRANS == 2'b00 || bus.HTRANS == 2'b10), 32'd1);
      if (hold_pending) begin
        check("hold_haddr", bus.HADDR, hold_addr);
        check("hold_hwrite", 32'(bus.HWRITE), 32'(hold_write));
        check("hold_htrans", 32'(bus.HTRANS), 32'd2);
      end
`ifdef CMSDK_AHB_DMA_CHKSUM_EN
      if (phase == 0 || phase == 3) check("chksum", chksum, chk_model);
`endif
      if (busy) tot_busy++;
      if (done) begin tot_done++; last_done_cyc = cyc; end
      if (error) tot_err++;
    end
  end

  int start_cyc;

  task automatic start_copy(input bit [31:0] s, input bit [31:0] d, input int len);
    @(negedge HCLK);
    cmd_src = s; cmd_dst = d; cmd_len = 16'(len); cmd_start = 1'b1; start_cyc = cyc;
    @(negedge HCLK);
    cmd_start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int k = 0;
    while (phase != 0 && k < budget) begin
      @(negedge HCLK);
      k++;
    end
    if (phase != 0) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: copy still active after %0d cycles, expected idle", budget);
    end
  endtask

  bit [31:0] rom [4];
  bit [31:0] exp_w [8];
  int b_busy, b_done, b_err, b_ns, b_wr;

  task automatic snap();
    b_busy = tot_busy; b_done = tot_done; b_err = tot_err; b_ns = n_nonseq; b_wr = n_writes_ok;
  endtask

  initial begin
    rom[0] = 32'hA5A5_0001; rom[1] = 32'h1234_5678; rom[2] = 32'hDEAD_BEEF; rom[3] = 32'h0F0F_F0F0;
    for (int i = 0; i < 4; i++) mem[32'h0000_0100 + 32'(4 * i)] = rom[i];
    repeat (3) @(posedge HCLK);
    chk_on = 1'b1;
    @(negedge HCLK);
    HRESETn = 1'b1;
    check("rst_htrans", 32'(bus.HTRANS), 32'd0);
    check("rst_haddr", bus.HADDR, 32'd0);
    check("rst_hwrite_hwdata", {31'd0, bus.HWRITE} | bus.HWDATA, 32'd0);
    check("rst_status", 32'({busy, done, error}), 32'd0);

    // 1: zero-wait ROM -> RAM copy
    snap();
    start_copy(32'h0000_0100, 32'h2000_0000, 4);
    wait_end(200);
    for (int i = 0; i < 4; i++) check("t1_ram", mem_rd(32'h2000_0000 + 32'(4 * i)), rom[i]);
    check("t1_busy_cycles", 32'(tot_busy - b_busy), 32'd17);
    check("t1_done_count", 32'(tot_done - b_done), 32'd1);
    check("t1_nonseq", 32'(n_nonseq - b_ns), 32'd8);
    check("t1_done_latency", 32'(last_done_cyc - start_cyc), 32'd18);

    // 2: same copy with random stalls
    stall_en = 1'b1;
    start_copy(32'h0000_0100, 32'h2000_0100, 4);
    wait_end(400);
    for (int i = 0; i < 4; i++) check("t2_ram", mem_rd(32'h2000_0100 + 32'(4 * i)), rom[i]);

    // 3: ERROR on the second write
    snap();
    mem[32'h2000_0204] = 32'h5555_AAAA;
    err_target = 1;
    start_copy(32'h0000_0100, 32'h2000_0200, 4);
    wait_end(400);
    repeat (4) @(negedge HCLK);
    err_target = -1;
    check("t3_error_count", 32'(tot_err - b_err), 32'd1);
    check("t3_done_count", 32'(tot_done - b_done), 32'd0);
    check("t3_writes", 32'(n_writes_ok - b_wr), 32'd1);
    check("t3_nonseq", 32'(n_nonseq - b_ns), 32'd4);
    check("t3_second_word_untouched", mem_rd(32'h2000_0204), 32'h5555_AAAA);

    // 4: len=0, then start while busy
    stall_en = 1'b0;
    snap();
    start_copy(32'h0000_0100, 32'h2000_0300, 0);
    wait_end(20);
    check("t4_done_latency", 32'(last_done_cyc - start_cyc), 32'd2);
    check("t4_no_bus", 32'(n_nonseq - b_ns), 32'd0);
    snap();
    start_copy(32'h0000_0100, 32'h2000_0300, 3);
    repeat (3) @(negedge HCLK);
    cmd_src = 32'h0000_0800; cmd_dst = 32'h2000_0800; cmd_len = 16'd9; cmd_start = 1'b1;
    @(negedge HCLK);
    cmd_start = 1'b0;
    wait_end(200);
    check("t4_busy_start_ignored", 32'(n_nonseq - b_ns), 32'd6);
    check("t4_done_once", 32'(tot_done - b_done), 32'd1);

    // 5: address wrap, then mid-copy reset
    start_copy(32'hFFFF_FFFC, 32'h3000_0000, 2);
    wait_end(100);
    check("t5_wrap_read", read_log[read_log.size() - 1], 32'h0000_0000);
    check("t5_wrap_data", mem_rd(32'h3000_0004), mem_rd(32'h0000_0000));
    snap();
    start_copy(32'h0000_0100, 32'h3000_0100, 4);
    repeat (5) @(negedge HCLK);
    HRESETn = 1'b0;
    @(negedge HCLK);
    check("t5_rst_htrans", 32'(bus.HTRANS), 32'd0);
    check("t5_rst_haddr", bus.HADDR, 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    HRESETn = 1'b1;
    repeat (12) @(negedge HCLK);
    check("t5_no_pulse", 32'((tot_done - b_done) + (tot_err - b_err)), 32'd0);

    // Random copies with stalls and unaligned command addresses
    stall_en = 1'b1;
    for (int it = 0; it < 6; it++) begin
      bit [31:0] s, d;
      int len;
      len = $urandom_range(1, 8);
      s = 32'h1000_0000 + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(0, 3));
      d = 32'h5000_0000 + 32'(it * 64) + 32'($urandom_range(0, 3));
      for (int i = 0; i < len; i++) exp_w[i] = mem_rd((s & ~32'h3) + 32'(4 * i));
      start_copy(s, d, len);
      wait_end(600);
      for (int i = 0; i < len; i++) check("rnd_ram", mem_rd((d & ~32'h3) + 32'(4 * i)), exp_w[i]);
    end

`ifdef CMSDK_AHB_DMA_CHKSUM_EN
    // 6: checksum of 1, 2, 4
    mem[32'h0000_0300] = 32'h1; mem[32'h0000_0304] = 32'h2; mem[32'h0000_0308] = 32'h4;
    start_copy(32'h0000_0300, 32'h2000_0400, 3);
    wait_end(300);
    check("t6_chksum", chksum, 32'h0000_0007);
`endif

    repeat (3) @(negedge HCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
